// File: rtl/rv32_types.sv
// Shared types for the RV32 load/store path.
//   mem_op_t          memory operation encoding (MEM_NOP = idle bus)
//   memory_request_t  op/addr/data bundle driven to the memory data port
//   lsu_err_t         response status of a load/store
//   lsu_state_t       load/store unit FSM states
// Helper functions classify operations and build store lane data.
package rv32_types;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  typedef struct packed {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_request_t;

  typedef enum logic [1:0] {
    LSU_OK           = 2'd0,
    LSU_MISALIGNED   = 2'd1,
    LSU_ACCESS_FAULT = 2'd2
  } lsu_err_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  function automatic logic is_store(input mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  // Halfword accesses need an even address, word accesses a 4-byte
  // aligned one; byte accesses are always aligned.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] low);
    logic mis;
    mis = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: mis = low[0];
      MEM_LW, MEM_SW:          mis = (low != 2'b00);
      default:                 mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Store data is right-aligned on input; the memory picks the lanes it
  // writes from op/addr, so the value is replicated into every lane.
  function automatic logic [31:0] store_replicate(input mem_op_t op, input logic [31:0] wdata);
    logic [31:0] lanes;
    lanes = '0;
    case (op)
      MEM_SB:  lanes = {4{wdata[7:0]}};
      MEM_SH:  lanes = {2{wdata[15:0]}};
      MEM_SW:  lanes = wdata;
      default: lanes = '0;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Load lane selection and extension (combinational).
//   op      load operation (MEM_LB/LH/LW/LBU/LHU; anything else yields 0)
//   addr    low two address bits selecting the byte/halfword lane
//   word    32-bit word read from memory
//   result  selected lane, sign- or zero-extended to 32 bits
module rv32_load_align
  import rv32_types::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{addr, 3'b000} +: 8];
    half_lane = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = '0;
    case (op)
      MEM_LB:  result = {{24{byte_lane[7]}}, byte_lane};
      MEM_LBU: result = {24'h000000, byte_lane};
      MEM_LH:  result = {{16{half_lane[15]}}, half_lane};
      MEM_LHU: result = {16'h0000, half_lane};
      MEM_LW:  result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rv32_load_store_unit.sv
// RV32 load/store unit: one outstanding memory operation at a time.
//   clk, resetn            clock; synchronous reset, active high
//   req_valid/req_ready    operation handshake (ready only when idle)
//   req_op/addr/wdata      operation, byte address, right-aligned store data
//   resp_valid/resp_ready  result handshake
//   resp_rdata/resp_err    extended load data (0 for stores/errors), status
//   data_request           op/addr/data to the memory data port
//   data_ready             memory reports data_request.addr in range
//   data                   memory read word, one cycle after the address
// Sequence: IDLE -> ISSUE -> (CAPTURE for loads) -> RESP -> IDLE;
// misaligned requests skip straight from IDLE to RESP.
module rv32_load_store_unit
  import rv32_types::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  mem_op_t         req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_rdata,
  output lsu_err_t        resp_err,
  output memory_request_t data_request,
  input  logic            data_ready,
  input  logic [31:0]     data
);

  lsu_state_t  state;
  mem_op_t     op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  lsu_err_t    err_q;
  logic [31:0] load_result;

  rv32_load_align u_load_align (
    .op     (op_q),
    .addr   (addr_q[1:0]),
    .word   (data),
    .result (load_result)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      state   <= IDLE;
      op_q    <= MEM_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= LSU_OK;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            if (is_misaligned(req_op, req_addr[1:0])) begin
              err_q <= LSU_MISALIGNED;
              state <= RESP;
            end else begin
              err_q <= LSU_OK;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!data_ready) begin
            err_q <= LSU_ACCESS_FAULT;
            state <= RESP;
          end else if (is_store(op_q)) begin
            state <= RESP;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rdata_q <= load_result;
          state   <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  // The memory commits a store on the edge that ends ISSUE. Masking the op
  // while reset is asserted keeps a store that is being reset out of
  // ISSUE from reaching memory on that same edge.
  always_comb begin
    data_request.op   = MEM_NOP;
    data_request.addr = '0;
    data_request.data = '0;
    case (state)
      ISSUE: begin
        data_request.addr = addr_q;
        data_request.data = store_replicate(op_q, wdata_q);
        if (data_ready && !resetn) begin
          data_request.op = op_q;
        end
      end
      CAPTURE: begin
        data_request.addr = addr_q;
      end
      default: begin
        data_request.op   = MEM_NOP;
        data_request.addr = '0;
        data_request.data = '0;
      end
    endcase
  end

endmodule
